// File: rtl/rl_ram_1r1w_stream_rd.sv
// Burst read engine: sequential reads from a 1R1W RAM read port, returned as a valid/ready stream
// through a 2-entry skid FIFO. Optional abort_i port is enabled by defining RL_RAM_RD_ABORT_EN.
module rl_ram_1r1w_stream_rd #(
  parameter int ABITS = 10,
  parameter int DBITS = 32,
  parameter int LBITS = ABITS + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [ABITS-1:0] addr_i,
  input  logic [LBITS-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [ABITS-1:0] raddr_o,
  input  logic [DBITS-1:0] rdata_i,
  output logic [DBITS-1:0] dout_o,
  output logic             dvalid_o,
  input  logic             dready_i,
  output logic             dlast_o
`ifdef RL_RAM_RD_ABORT_EN
  ,
  input  logic             abort_i
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [LBITS-1:0] LEN_ONE = LBITS'(1);

  logic [1:0]       state_q, state_d;
  logic [ABITS-1:0] raddr_q, raddr_d;
  logic [LBITS-1:0] cnt_q, cnt_d;
  logic             inflight_q, inflight_d;
  logic             infl_last_q, infl_last_d;
  logic             done_q, done_d;
  logic [DBITS-1:0] mem_q [2];
  logic [DBITS-1:0] mem_d [2];
  logic [1:0]       lastf_q, lastf_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       fcnt_q, fcnt_d;

  logic             abort_w;
  logic             pop;
  logic             push;
  logic             issue;
  logic [2:0]       occ;

`ifdef RL_RAM_RD_ABORT_EN
  assign abort_w = abort_i;
`else
  assign abort_w = 1'b0;
`endif

  assign pop  = (fcnt_q != 2'd0) && dready_i;
  assign push = inflight_q;
  // Occupancy once the in-flight beat lands; holding it below 2 keeps the FIFO from overflowing.
  assign occ   = {1'b0, fcnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (state_q == ST_RUN) && (occ < 3'd2);

  always_comb begin
    state_d     = state_q;
    raddr_d     = raddr_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    inflight_d  = issue;
    infl_last_d = issue && (cnt_q == LEN_ONE);
    mem_d       = mem_q;
    lastf_d     = lastf_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fcnt_d      = fcnt_q + {1'b0, push} - {1'b0, pop};

    if (push) begin
      mem_d[wr_ptr_q]   = rdata_i;
      lastf_d[wr_ptr_q] = infl_last_q;
      wr_ptr_d          = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            raddr_d = addr_i;
            cnt_d   = len_i;
            state_d = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (issue) begin
          raddr_d = raddr_q + 1'b1;
          cnt_d   = cnt_q - LEN_ONE;
          if (cnt_q == LEN_ONE) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pop && lastf_q[rd_ptr_q]) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort drops everything queued or in flight and returns to IDLE without a done pulse.
    if (abort_w && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      done_d      = 1'b0;
      inflight_d  = 1'b0;
      infl_last_d = 1'b0;
      fcnt_d      = 2'd0;
      wr_ptr_d    = 1'b0;
      rd_ptr_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      raddr_q     <= '0;
      cnt_q       <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
      mem_q       <= '{default: '0};
      lastf_q     <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      fcnt_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      raddr_q     <= raddr_d;
      cnt_q       <= cnt_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
      mem_q       <= mem_d;
      lastf_q     <= lastf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fcnt_q      <= fcnt_d;
    end
  end

  assign busy_o   = (state_q != ST_IDLE);
  assign done_o   = done_q;
  assign raddr_o  = raddr_q;
  assign dvalid_o = (fcnt_q != 2'd0);
  assign dout_o   = mem_q[rd_ptr_q];
  assign dlast_o  = dvalid_o && lastf_q[rd_ptr_q];

endmodule

// File: tb/tb_rl_ram_1r1w_stream_rd.sv
// Bench for rl_ram_1r1w_stream_rd: table-driven bursts, reset/abort sequences and random bursts
// scored against a queue of expected beats derived from RAM contents.
module tb_rl_ram_1r1w_stream_rd;
  localparam int ABITS = 10;
  localparam int DBITS = 32;
  localparam int LBITS = ABITS + 1;
  localparam int DEPTH = 1 << ABITS;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             start_i;
  logic [ABITS-1:0] addr_i;
  logic [LBITS-1:0] len_i;
  logic             busy_o;
  logic             done_o;
  logic [ABITS-1:0] raddr_o;
  logic [DBITS-1:0] rdata_i = '0;
  logic [DBITS-1:0] dout_o;
  logic             dvalid_o;
  logic             dready_i;
  logic             dlast_o;
`ifdef RL_RAM_RD_ABORT_EN
  logic             abort_i = 1'b0;
`endif

  rl_ram_1r1w_stream_rd #(.ABITS(ABITS), .DBITS(DBITS), .LBITS(LBITS)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .start_i (start_i),
    .addr_i  (addr_i),
    .len_i   (len_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .raddr_o (raddr_o),
    .rdata_i (rdata_i),
    .dout_o  (dout_o),
    .dvalid_o(dvalid_o),
    .dready_i(dready_i),
    .dlast_o (dlast_o)
`ifdef RL_RAM_RD_ABORT_EN
    ,
    .abort_i (abort_i)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data for the address sampled at an edge is visible after that edge.
  logic [DBITS-1:0] ram [DEPTH];
  always @(posedge clk) rdata_i <= ram[raddr_o];

  typedef struct {
    logic [ABITS-1:0] addr;
    int               len;
    int               mode;      // 0: ready=1, 1: ready pattern 1,0,0,1, 2: random ready
    int               exp_done;  // edge index of done_o, -1 when ready is irregular
    bit               stray;     // extra start_i mid-burst, which must be ignored
  } vec_t;

  vec_t             tv [6];
  logic [DBITS-1:0] exp_d [$];
  logic             exp_l [$];
  int  total = 0;
  int  bad = 0;
  int  k, done_cnt, done_k, first_k, xfers;
  bit  abort_now = 1'b0;
  logic [3:0] pat = 4'b1001;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: score any transfer at this edge, then observe outputs 1 time unit after it.
  task automatic cycle();
    logic pv, pr, pl;
    logic [DBITS-1:0] pd;
    pv = dvalid_o; pr = dready_i; pd = dout_o; pl = dlast_o;
    if (pv && pr) begin
      if (exp_d.size() == 0) check("extra_beat", 64'(pd), 64'hDEAD_BEEF_0000_0000);
      else begin
        check("beat_data", 64'(pd), 64'(exp_d.pop_front()));
        check("beat_last", 64'(pl), 64'(exp_l.pop_front()));
      end
      xfers++;
    end
    @(posedge clk);
    #1;
    if (done_o) begin done_cnt++; done_k = k; end
    if (dvalid_o && first_k < 0) first_k = k;
    if (pv && !pr && !abort_now) begin
      check("stall_valid", 64'(dvalid_o), 64'd1);
      check("stall_data", 64'(dout_o), 64'(pd));
      check("stall_last", 64'(dlast_o), 64'(pl));
    end
    k++;
  endtask

  task automatic expect_burst(input logic [ABITS-1:0] a, input int len);
    for (int i = 0; i < len; i++) begin
      exp_d.push_back(ram[(int'(a) + i) % DEPTH]);
      exp_l.push_back(i == len - 1);
    end
  endtask

  task automatic run_burst(input logic [ABITS-1:0] a, input int len, input int mode,
                           input int exp_done, input bit stray);
    int budget;
    expect_burst(a, len);
    k = 0; done_cnt = 0; done_k = -1; first_k = -1;
    start_i = 1'b1; addr_i = a; len_i = LBITS'(len); dready_i = 1'b1;
    cycle();
    start_i = 1'b0;
    check("busy_start", 64'(busy_o), 64'(len != 0));
    if (len != 0) check("raddr_latch", 64'(raddr_o), 64'(a));
    budget = 4 * len + 20;
    while (done_cnt == 0 && k < budget) begin
      if (mode == 0) dready_i = 1'b1;
      else if (mode == 1) dready_i = pat[k % 4];
      else dready_i = 1'($urandom_range(0, 1));
      if (stray && k == 3) begin
        start_i = 1'b1; addr_i = 10'h155; len_i = LBITS'(5);
      end else start_i = 1'b0;
      cycle();
    end
    start_i = 1'b0;
    check("done_seen", 64'(done_cnt), 64'd1);
    if (exp_done >= 0) check("done_cycle", 64'(done_k), 64'(exp_done));
    check("first_valid", 64'(first_k), 64'(len == 0 ? -1 : 2));
    check("busy_after", 64'(busy_o), 64'd0);
    check("beats_left", 64'(exp_d.size()), 64'd0);
    dready_i = 1'b1;
    cycle();
    check("done_once", 64'(done_cnt), 64'd1);
    check("idle_valid", 64'(dvalid_o), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_done"}, 64'(done_o), 64'd0);
    check({tag, "_valid"}, 64'(dvalid_o), 64'd0);
    check({tag, "_last"}, 64'(dlast_o), 64'd0);
    check({tag, "_raddr"}, 64'(raddr_o), 64'd0);
    check({tag, "_dout"}, 64'(dout_o), 64'd0);
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; addr_i = '0; len_i = '0; dready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) ram[i] = DBITS'(i);
    tv[0] = '{10'h010, 4, 0, 6,  1'b0};
    tv[1] = '{10'h020, 8, 1, -1, 1'b0};
    tv[2] = '{10'h3FE, 4, 0, 6,  1'b0};
    tv[3] = '{10'h000, 0, 0, 0,  1'b0};
    tv[4] = '{10'h040, 8, 0, 10, 1'b1};
    tv[5] = '{10'h3F0, 1, 2, -1, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_ni = 1'b1;
    xfers = 0;

    for (int t = 0; t < 6; t++) run_burst(tv[t].addr, tv[t].len, tv[t].mode, tv[t].exp_done, tv[t].stray);

    // Reset in the middle of a 10-beat burst, after three beats have gone out.
    expect_burst(10'h080, 10);
    k = 0; done_cnt = 0; done_k = -1; first_k = -1; xfers = 0;
    start_i = 1'b1; addr_i = 10'h080; len_i = LBITS'(10); dready_i = 1'b1;
    cycle();
    start_i = 1'b0;
    while (xfers < 3 && k < 20) cycle();
    check("pre_reset_xfers", 64'(xfers), 64'd3);
    #2 rst_ni = 1'b0;
    #1;
    check_all_zero("midrst");
    exp_d.delete(); exp_l.delete();
    @(posedge clk); @(posedge clk); #1;
    check("rst_done", 64'(done_o), 64'd0);
    rst_ni = 1'b1;
    run_burst(10'h090, 6, 0, 8, 1'b0);

`ifdef RL_RAM_RD_ABORT_EN
    // Abort with beat 5 of 16 stalled at the head.
    expect_burst(10'h200, 16);
    k = 0; done_cnt = 0; done_k = -1; first_k = -1; xfers = 0;
    start_i = 1'b1; addr_i = 10'h200; len_i = LBITS'(16); dready_i = 1'b1;
    cycle();
    start_i = 1'b0;
    while (xfers < 4 && k < 30) cycle();
    dready_i = 1'b0; abort_i = 1'b1; abort_now = 1'b1;
    cycle();
    abort_i = 1'b0; abort_now = 1'b0;
    check("abort_valid", 64'(dvalid_o), 64'd0);
    check("abort_busy", 64'(busy_o), 64'd0);
    exp_d.delete(); exp_l.delete();
    dready_i = 1'b1;
    repeat (3) cycle();
    check("abort_done", 64'(done_cnt), 64'd0);
    check("abort_quiet", 64'(dvalid_o), 64'd0);
    run_burst(10'h300, 5, 0, 7, 1'b0);
`endif

    for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
    for (int r = 0; r < 6; r++)
      run_burst(ABITS'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)), 2, -1, 1'b0);
    run_burst(ABITS'($urandom_range(0, DEPTH - 1)), DEPTH, 0, DEPTH + 2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
